mrclk_restart_seq: RTL and testbench
====================================

Name: mrclk_restart_seq

Overview:
- Control sequencer that drives the CE pin of the multi-region clock buffer and the CLR pin of the regional dividers it feeds.
- Runs the mandated safe restart order:
  1. gate the multi-region clock off;
  2. pulse the divider clear;
  3. release the clear;
  4. re-enable the clock;
  5. wait out a settle interval.
- Runs on the free-running system clock, never the gated clock.
- Starts one sequence automatically after reset and further sequences on a four-phase request/acknowledge handshake.

Parameters:
- T_OFF, 4: cycles CE is held low before the clear is asserted (≥1).
- T_CLR, 8: cycles bufr_clr is held high (≥1).
- T_REL, 4: cycles between clear release and CE re-assert (≥1).
- T_SETTLE, 16: cycles after CE re-assert before busy drops (≥1).
- CNT_W, 8: width of the shared down-counter. Every T_* must be ≤ 2^CNT_W; checked at elaboration, fatal on violation.

Ports:
- clk  in  1  free-running system clock
- reset_n  in  1  asynchronous active-low reset; deassertion synchronous to clk externally
- restart_req  in  1  restart request level, clk domain
- restart_ack  out  1  acknowledge level of the four-phase handshake
- busy  out  1  sequence in progress
- bufmr_ce  out  1  CE to the multi-region buffer (active high)
- bufr_clr  out  1  async clear to the regional dividers (active high)
- mmcm_locked  in  1  source PLL/MMCM lock, asynchronous; used only with the optional feature

Behaviour:
- Outputs are registered; all decode comes from the state register, no combinational paths from inputs.
- Reset values (reset_n low): state S_CLR with counter loaded to T_CLR-1; bufmr_ce=0, bufr_clr=1, busy=1, restart_ack=0, auto flag=1.
- Counter rule: each state loads N-1 on entry, decrements every cycle, and exits on the edge where the count is 0. State occupancy is exactly N cycles.
- States and outputs (ce/clr/busy):
  - S_IDLE (1/0/0)
  - S_OFF (0/0/1), T_OFF
  - S_CLR (0/1/1), T_CLR
  - S_REL (0/0/1), T_REL
  - S_ON (1/0/1), T_SETTLE
  - S_ACK (1/0/0)
- Transitions:
  - S_IDLE → S_OFF when restart_req=1 and restart_ack=0; clears the auto flag.
  - S_OFF → S_CLR → S_REL → S_ON, each on counter expiry.
  - S_ON → S_ACK on expiry if the auto flag is 0.
  - S_ON → S_IDLE on expiry if the auto flag is 1. The power-on sequence never acks.
  - S_ACK: restart_ack=1, held until restart_req=0. Then restart_ack=0 and the state goes to S_IDLE on the same edge.
- restart_req changing while busy=1 is ignored; the sequence is never aborted or extended.
- A request still high when an auto sequence ends is seen in S_IDLE and starts a fresh sequence one cycle later.
- Request pulses shorter than one cycle are not guaranteed to be seen; this is the requester's contract.
- bufmr_ce and bufr_clr are never both 1 in any cycle. bufr_clr only rises while bufmr_ce has been 0 for at least T_OFF cycles.
- reset_n asserted mid-sequence forces reset values immediately, with no glitch to ce=1. The power-on sequence restarts from S_CLR after deassertion.

Optional Feature:
- Macro: MRCLK_LOCK_GATE_EN.
- Defined:
  - mmcm_locked goes through a 2-flop synchronizer (reset value 0).
  - S_REL exits only when the counter has expired AND locked_sync=1; the counter holds at 0 while waiting.
  - In S_IDLE or S_ACK, locked_sync=0 forces S_OFF with the auto flag set, and restart_ack is dropped. The auto sequence then ends in S_IDLE; the requester re-requests.
- Undefined: mmcm_locked is ignored and left unconnected internally; the port remains for pin compatibility.

Decomposition:
- Package mrclk_seq_pkg holds:
  - the state enum type (S_IDLE, S_OFF, S_CLR, S_REL, S_ON, S_ACK);
  - the default T_* constants;
  - the function that checks a T_* value against CNT_W.
- One sub-module: sync2_ff, a 2-flop async-reset synchronizer, instantiated only under MRCLK_LOCK_GATE_EN.

Test Plan:
- Power-on, defaults: hold reset_n low 5 cycles, then release → bufr_clr=1 for 8 cycles; then 0/0 for 4 cycles; then bufmr_ce=1; busy falls 16 cycles later; restart_ack stays 0 throughout.
- Handshake: restart_req=1 in idle → ce=0 next edge, then 4 off / 8 clr / 4 rel / 16 settle cycles; restart_ack=1 and busy=0. Drop req → ack=0 one edge later.
- Busy rejection: toggle restart_req 0→1→0→1 during S_CLR → sequence timing unchanged; one ack only, after S_ON ends.
- Mid-sequence reset: assert reset_n during S_ON → bufmr_ce=0 and bufr_clr=1 asynchronously; the power-on sequence reruns after release.
- Invariant check: assertion that ce&clr is never true, and that clr rises only after ce has been low ≥4 cycles, across randomized req traffic over 10k cycles.
- With MRCLK_LOCK_GATE_EN: hold mmcm_locked=0 → sequence parks in S_REL with ce=0. Raise lock → ce=1 within 3 cycles. Drop lock in idle → auto restart with no ack.

Source files
------------

// File: rtl/mrclk_restart_seq_pkg.sv
// Shared types and constants for the multi-region clock restart sequencer.
// Latency: n/a (types, constants and an elaboration-time range check only).
// Backpressure: n/a.
package mrclk_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_OFF  = 3'd1,
    S_CLR  = 3'd2,
    S_REL  = 3'd3,
    S_ON   = 3'd4,
    S_ACK  = 3'd5
  } state_e;

  localparam int T_OFF_DEF    = 4;
  localparam int T_CLR_DEF    = 8;
  localparam int T_REL_DEF    = 4;
  localparam int T_SETTLE_DEF = 16;
  localparam int CNT_W_DEF    = 8;

  // A phase of length t loads t-1, so t must be in 1 .. 2^cnt_w.
  function automatic bit t_fits(input int t, input int cnt_w);
    return (t >= 1) && (longint'(t) <= (longint'(1) << cnt_w));
  endfunction

endpackage

// File: rtl/mrclk_restart_seq_if.sv
// Four-phase restart handshake between a requester and the clock restart sequencer.
// Latency: n/a (wires only).
// Backpressure: requester holds restart_req until restart_ack rises, then drops it.
//   master : requester side   (drives restart_req)
//   slave  : sequencer side   (drives restart_ack, busy)
interface mrclk_restart_seq_if;
  logic restart_req;
  logic restart_ack;
  logic busy;

  modport master (output restart_req, input restart_ack, input busy);
  modport slave  (input restart_req, output restart_ack, output busy);
endinterface

// File: rtl/mrclk_restart_seq_sync2_ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// Latency: 2 clk edges from d to q.
// Backpressure: none.
//   clk, reset_n (async active-low, q resets to 0), d (async in), q (synced out)
module sync2_ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/mrclk_restart_seq.sv
// Safe restart sequencer for a multi-region clock buffer: CE off, divider clear pulse, release, CE on, settle.
// Latency: request seen on the next clk edge; full sequence T_OFF+T_CLR+T_REL+T_SETTLE cycles, then ack.
// Backpressure: requests are ignored while busy; ack is held until the requester drops restart_req.
//   clk          free-running system clock (never the gated clock)
//   reset_n      async active-low reset; power-on sequence starts in the clear phase
//   req_if       restart_req / restart_ack / busy handshake (slave side)
//   bufmr_ce     CE to the multi-region buffer, bufr_clr clear to the regional dividers
//   mmcm_locked  source lock, used only when MRCLK_LOCK_GATE_EN is defined
module mrclk_restart_seq
  import mrclk_seq_pkg::*;
#(
  parameter int T_OFF    = T_OFF_DEF,
  parameter int T_CLR    = T_CLR_DEF,
  parameter int T_REL    = T_REL_DEF,
  parameter int T_SETTLE = T_SETTLE_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  mrclk_restart_seq_if.slave  req_if,
  output logic                bufmr_ce,
  output logic                bufr_clr,
  input  logic                mmcm_locked
);

  if (!t_fits(T_OFF, CNT_W)) begin : g_bad_t_off
    $fatal(1, "mrclk_restart_seq: T_OFF out of range for CNT_W");
  end
  if (!t_fits(T_CLR, CNT_W)) begin : g_bad_t_clr
    $fatal(1, "mrclk_restart_seq: T_CLR out of range for CNT_W");
  end
  if (!t_fits(T_REL, CNT_W)) begin : g_bad_t_rel
    $fatal(1, "mrclk_restart_seq: T_REL out of range for CNT_W");
  end
  if (!t_fits(T_SETTLE, CNT_W)) begin : g_bad_t_settle
    $fatal(1, "mrclk_restart_seq: T_SETTLE out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] LD_OFF    = CNT_W'(T_OFF - 1);
  localparam logic [CNT_W-1:0] LD_CLR    = CNT_W'(T_CLR - 1);
  localparam logic [CNT_W-1:0] LD_REL    = CNT_W'(T_REL - 1);
  localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(T_SETTLE - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic lock_ok;

`ifdef MRCLK_LOCK_GATE_EN
  logic locked_sync;

  sync2_ff u_lock_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (mmcm_locked),
    .q       (locked_sync)
  );

  assign lock_ok = locked_sync;
`else
  // Pin kept for compatibility; the lock level plays no part in sequencing.
  logic unused_mmcm_locked;
  assign unused_mmcm_locked = mmcm_locked;
  assign lock_ok            = 1'b1;
`endif

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             auto_q, auto_d;
  logic             ce_q, clr_q, busy_q, ack_q;
  logic             ce_d, clr_d, busy_d, ack_d;
  logic             expired;

  assign expired = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = expired ? cnt_q : (cnt_q - CNT_ONE);
    auto_d  = auto_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_if.restart_req && !ack_q) begin
          state_d = S_OFF;
          cnt_d   = LD_OFF;
          auto_d  = 1'b0;
        end
      end
      S_OFF: begin
        if (expired) begin
          state_d = S_CLR;
          cnt_d   = LD_CLR;
        end
      end
      S_CLR: begin
        if (expired) begin
          state_d = S_REL;
          cnt_d   = LD_REL;
        end
      end
      S_REL: begin
        // Counter parks at zero while waiting for lock.
        if (expired && lock_ok) begin
          state_d = S_ON;
          cnt_d   = LD_SETTLE;
        end
      end
      S_ON: begin
        if (expired) begin
          state_d = auto_q ? S_IDLE : S_ACK;
        end
      end
      S_ACK: begin
        if (!req_if.restart_req) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Lost lock while the clock is running: restart on our own, no ack owed.
    if (!lock_ok && (state_q == S_IDLE || state_q == S_ACK)) begin
      state_d = S_OFF;
      cnt_d   = LD_OFF;
      auto_d  = 1'b1;
    end
  end

  // Outputs are decoded from the next state and registered, so pins never
  // see decode glitches and move on the same edge as the state.
  always_comb begin
    ce_d   = 1'b0;
    clr_d  = 1'b0;
    busy_d = 1'b1;
    ack_d  = 1'b0;
    unique case (state_d)
      S_IDLE:  begin ce_d = 1'b1; busy_d = 1'b0; end
      S_OFF:   begin end
      S_CLR:   clr_d = 1'b1;
      S_REL:   begin end
      S_ON:    ce_d = 1'b1;
      S_ACK:   begin ce_d = 1'b1; busy_d = 1'b0; ack_d = 1'b1; end
      default: begin end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_CLR;
      cnt_q   <= LD_CLR;
      auto_q  <= 1'b1;
      ce_q    <= 1'b0;
      clr_q   <= 1'b1;
      busy_q  <= 1'b1;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      auto_q  <= auto_d;
      ce_q    <= ce_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      ack_q   <= ack_d;
    end
  end

  assign bufmr_ce           = ce_q;
  assign bufr_clr           = clr_q;
  assign req_if.busy        = busy_q;
  assign req_if.restart_ack = ack_q;

endmodule

// File: tb/tb_mrclk_restart_seq.sv
// Directed + random bench for the clock restart sequencer.
// Latency: n/a.
// Backpressure: n/a.
module tb_mrclk_restart_seq;

  logic clk = 1'b0;
  logic reset_n;
  logic mmcm_locked;
  logic bufmr_ce;
  logic bufr_clr;

  mrclk_restart_seq_if rif ();

  mrclk_restart_seq dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_if      (rif),
    .bufmr_ce    (bufmr_ce),
    .bufr_clr    (bufr_clr),
    .mmcm_locked (mmcm_locked)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Observation vector {ce, clr, busy, ack}
  typedef logic [3:0] obs_t;
  localparam obs_t P_IDLE = 4'b1000;
  localparam obs_t P_OFF  = 4'b0010;
  localparam obs_t P_CLR  = 4'b0110;
  localparam obs_t P_REL  = 4'b0010;
  localparam obs_t P_ON   = 4'b1010;
  localparam obs_t P_ACK  = 4'b1001;
  localparam obs_t P_RST  = 4'b0110;

  typedef struct {
    obs_t  exp;
    string tag;
  } sb_t;

  sb_t sb_q[$];

  function automatic obs_t cur_obs();
    return {bufmr_ce, bufr_clr, rif.busy, rif.restart_ack};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected per-cycle outputs, one entry per clk edge after the stimulus.
  task automatic push(input obs_t p, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      sb_t e;
      e.exp = p;
      e.tag = $sformatf("%s[%0d]", tag, i);
      sb_q.push_back(e);
    end
  endtask

  task automatic drain();
    while (sb_q.size() > 0) begin
      sb_t e;
      @(negedge clk);
      e = sb_q.pop_front();
      check(e.tag, 32'(cur_obs()), 32'(e.exp));
    end
  endtask

  // Safety invariants sampled every cycle outside reset.
  int   ce_low   = 0;
  logic clr_prev = 1'b1;
  logic rst_prev = 1'b0;

  always @(negedge clk) begin
    if (reset_n === 1'b1 && rst_prev === 1'b1) begin
      n_cmp++;
      assert (!(bufmr_ce === 1'b1 && bufr_clr === 1'b1)) else begin
        n_mis++;
        $error("FAIL inv_ce_and_clr: observed ce=%b clr=%b expected not both 1", bufmr_ce, bufr_clr);
      end
      if (bufr_clr === 1'b1 && clr_prev === 1'b0) begin
        n_cmp++;
        assert (ce_low >= 4) else begin
          n_mis++;
          $error("FAIL inv_clr_rise: observed ce low %0d cycles expected >= 4", ce_low);
        end
      end
    end
    ce_low   = (bufmr_ce === 1'b0) ? ce_low + 1 : 0;
    clr_prev = bufr_clr;
    rst_prev = reset_n;
  end

  initial begin
    int n;
    reset_n         = 1'b0;
    rif.restart_req = 1'b0;
    mmcm_locked     = 1'b1;

    // Reset values held for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("reset_val[%0d]", i), 32'(cur_obs()), 32'(P_RST));
    end

    // Power-on sequence, no ack.
    reset_n = 1'b1;
    push(P_CLR, 7, "pwr_clr");
    push(P_REL, 4, "pwr_rel");
    push(P_ON, 16, "pwr_on");
    push(P_IDLE, 2, "pwr_idle");
    drain();

    // Full handshake.
    rif.restart_req = 1'b1;
    push(P_OFF, 4, "hs_off");
    push(P_CLR, 8, "hs_clr");
    push(P_REL, 4, "hs_rel");
    push(P_ON, 16, "hs_on");
    push(P_ACK, 3, "hs_ack");
    drain();
    rif.restart_req = 1'b0;
    push(P_IDLE, 2, "hs_idle");
    drain();

    // Request toggling during the clear phase must not disturb timing.
    rif.restart_req = 1'b1;
    push(P_OFF, 4, "bz_off");
    drain();
    rif.restart_req = 1'b0;
    push(P_CLR, 2, "bz_clr_a");
    drain();
    rif.restart_req = 1'b1;
    push(P_CLR, 2, "bz_clr_b");
    drain();
    rif.restart_req = 1'b0;
    push(P_CLR, 2, "bz_clr_c");
    drain();
    rif.restart_req = 1'b1;
    push(P_CLR, 2, "bz_clr_d");
    push(P_REL, 4, "bz_rel");
    push(P_ON, 16, "bz_on");
    push(P_ACK, 2, "bz_ack");
    drain();
    rif.restart_req = 1'b0;
    push(P_IDLE, 3, "bz_idle");
    drain();

    // Reset in the settle phase; request held through release is served after the auto run.
    rif.restart_req = 1'b1;
    push(P_OFF, 4, "mr_off");
    push(P_CLR, 8, "mr_clr");
    push(P_REL, 4, "mr_rel");
    push(P_ON, 5, "mr_on");
    drain();
    #2 reset_n = 1'b0;
    #1 check("mr_async_rst", 32'(cur_obs()), 32'(P_RST));
    @(negedge clk);
    check("mr_rst_hold_a", 32'(cur_obs()), 32'(P_RST));
    @(negedge clk);
    check("mr_rst_hold_b", 32'(cur_obs()), 32'(P_RST));
    reset_n = 1'b1;
    push(P_CLR, 7, "mr_pwr_clr");
    push(P_REL, 4, "mr_pwr_rel");
    push(P_ON, 16, "mr_pwr_on");
    push(P_IDLE, 1, "mr_pwr_idle");
    push(P_OFF, 4, "mr_req_off");
    push(P_CLR, 8, "mr_req_clr");
    push(P_REL, 4, "mr_req_rel");
    push(P_ON, 16, "mr_req_on");
    push(P_ACK, 2, "mr_req_ack");
    drain();
    rif.restart_req = 1'b0;
    push(P_IDLE, 2, "mr_idle");
    drain();

    // Random request traffic; invariants are checked by the monitor.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) rif.restart_req = ~rif.restart_req;
    end
    rif.restart_req = 1'b0;
    n = 0;
    while (!(rif.busy === 1'b0 && rif.restart_ack === 1'b0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("rand_quiesce", 32'(n < 200), 32'd1);
    push(P_IDLE, 2, "rand_idle");
    drain();

`ifdef MRCLK_LOCK_GATE_EN
    // Lock loss in idle: self-started restart, parks before CE, no ack.
    mmcm_locked = 1'b0;
    n = 0;
    while (rif.busy !== 1'b1 && n < 6) begin
      @(negedge clk);
      n++;
    end
    check("lock_drop_busy", 32'(rif.busy), 32'd1);
    check("lock_drop_ack", 32'(rif.restart_ack), 32'd0);
    repeat (30) @(negedge clk);
    check("lock_park", 32'(cur_obs()), 32'(P_REL));
    mmcm_locked = 1'b1;
    n = 0;
    while (bufmr_ce !== 1'b1 && n < 8) begin
      @(negedge clk);
      n++;
    end
    check("lock_ce_latency", 32'(n >= 1 && n <= 3), 32'd1);
    n = 0;
    while (rif.busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("lock_end_idle", 32'(cur_obs()), 32'(P_IDLE));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
